// File: rtl/fcp_master_burst_if.sv
// rtl/fcp_master_burst_if.sv - host-side request/stream bundle of the FCP6 burst master
//
// Purpose: groups the host-facing handshake of fcp_master_burst so the master
// and the host logic see the same signal set.
// Signals:
//   start      host -> master  request a transaction (sampled only when idle)
//   header_in  host -> master  header byte, bit0 = 1 write / 0 read
//   len_in     host -> master  burst length in bytes (0 -> 1, clamped to MAX_LEN)
//   wr_data    host -> master  next write byte
//   wr_valid   host -> master  wr_data is valid
//   wr_ready   master -> host  write byte accepted this cycle
//   rd_data    master -> host  last received byte
//   rd_valid   master -> host  one-cycle pulse, rd_data is new
//   busy       master -> host  transaction in progress
//   done       master -> host  one-cycle pulse, normal completion
//   err        master -> host  one-cycle pulse, transaction aborted
//   err_code   master -> host  abort cause, held until the next start
interface fcp_master_burst_if #(
  parameter int LEN_W = 5
);
  logic             start;
  logic [7:0]       header_in;
  logic [LEN_W-1:0] len_in;
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;

  modport master (
    input  start, header_in, len_in, wr_data, wr_valid,
    output wr_ready, rd_data, rd_valid, busy, done, err, err_code
  );

  modport slave (
    output start, header_in, len_in, wr_data, wr_valid,
    input  wr_ready, rd_data, rd_valid, busy, done, err, err_code
  );
endinterface

// File: rtl/fcp_master_burst.sv
// rtl/fcp_master_burst.sv - FCP6 bus master: header phase then write or read burst
//
// Purpose: drives an FCP6 header, then a multi-byte write or read burst over a
// LANE_W-bit shared data bus, with per-byte acknowledge and ACK timeout.
// Ports:
//   i_clk    single clock, rising edge only
//   i_rst    synchronous active-high reset; releases the bus on the same edge
//   bus      host-side request/stream bundle (fcp_master_burst_if.master)
//   io_data  shared data bus, LANE_W bits, MSB lane first
//   io_ack   acknowledge line, pulled up externally, 0 = ACK
//   io_ctrl  bus control: 01 master owns, 10 slave owns, 11 stop
module fcp_master_burst #(
  parameter int LANE_W      = 2,
  parameter int MAX_LEN     = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  fcp_master_burst_if.master    bus,
  inout  wire  [LANE_W-1:0]     io_data,
  inout  wire                   io_ack,
  inout  wire  [1:0]            io_ctrl
);

  localparam int BEATS = 8 / LANE_W;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW    = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_HDR_ACK, S_WR_FETCH, S_WR_SEND, S_WR_ACK,
    S_RD_TURN, S_RD_RECV, S_RD_ACK, S_STOP, S_ABORT
  } state_t;

  state_t            r_state;
  logic [BW-1:0]     r_beat;
  logic [TW-1:0]     r_tmo;
  logic [LEN_W-1:0]  r_rem;
  logic              r_is_wr;
  logic [7:0]        r_tx;
  logic [7:0]        r_shift;
  logic              r_data_en;
  logic [LANE_W-1:0] r_data_o;
  logic              r_ack_en;
  logic              r_ack_o;
  logic              r_ctrl_en;
  logic [1:0]        r_ctrl_o;
  logic              r_wr_ready;
  logic [7:0]        r_rd_data;
  logic              r_rd_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic [LEN_W-1:0]  w_len;
  logic              w_ack_seen;
  logic              w_stop_seen;
  logic              w_tmo_hit;
  logic              w_last_beat;
  logic              w_last_byte;
  logic [7:0]        w_shift_in;

  always_comb begin
    w_len = bus.len_in;
    if (bus.len_in == '0) begin
      w_len = LEN_W'(1);
    end else if (bus.len_in > LEN_W'(MAX_LEN)) begin
      w_len = LEN_W'(MAX_LEN);
    end
  end

  assign w_ack_seen  = (io_ack == 1'b0);
  assign w_stop_seen = (io_ctrl == 2'b11);
  assign w_tmo_hit   = (r_tmo == TW'(ACK_TIMEOUT));
  assign w_last_beat = (r_beat == BW'(BEATS - 1));
  assign w_last_byte = (r_rem == LEN_W'(1));
  // New lane enters at the LSB end; after BEATS beats the first lane is the MSB.
  assign w_shift_in  = 8'({r_shift, io_data});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_tmo      <= '0;
      r_rem      <= '0;
      r_is_wr    <= 1'b0;
      r_tx       <= '0;
      r_shift    <= '0;
      r_data_en  <= 1'b0;
      r_data_o   <= '0;
      r_ack_en   <= 1'b0;
      r_ack_o    <= 1'b1;
      r_ctrl_en  <= 1'b0;
      r_ctrl_o   <= 2'b00;
      r_wr_ready <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_HDR;
            r_busy     <= 1'b1;
            r_err_code <= 2'b00;
            r_is_wr    <= bus.header_in[0];
            r_rem      <= w_len;
            r_beat     <= '0;
            r_ctrl_en  <= 1'b1;
            r_ctrl_o   <= 2'b01;
            r_data_en  <= 1'b1;
            r_data_o   <= bus.header_in[7 -: LANE_W];
            r_tx       <= bus.header_in << LANE_W;
          end
        end

        S_HDR, S_WR_SEND: begin
          if (w_last_beat) begin
            r_state   <= (r_state == S_HDR) ? S_HDR_ACK : S_WR_ACK;
            r_data_en <= 1'b0;
            r_tmo     <= '0;
          end else begin
            r_beat   <= r_beat + 1'b1;
            r_data_o <= r_tx[7 -: LANE_W];
            r_tx     <= r_tx << LANE_W;
          end
        end

        S_HDR_ACK: begin
          if (w_ack_seen) begin
            if (r_is_wr) begin
              r_state    <= S_WR_FETCH;
              r_wr_ready <= 1'b1;
            end else begin
              // Hand the bus to the slave: release ctrl for the turnaround cycle.
              r_state   <= S_RD_TURN;
              r_ctrl_en <= 1'b0;
            end
          end else if (w_tmo_hit) begin
            r_state    <= S_ABORT;
            r_err_code <= 2'b01;
            r_ctrl_o   <= 2'b11;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        S_WR_FETCH: begin
          if (bus.wr_valid && r_wr_ready) begin
            r_state    <= S_WR_SEND;
            r_wr_ready <= 1'b0;
            r_beat     <= '0;
            r_data_en  <= 1'b1;
            r_data_o   <= bus.wr_data[7 -: LANE_W];
            r_tx       <= bus.wr_data << LANE_W;
          end
        end

        S_WR_ACK: begin
          if (w_ack_seen) begin
            r_rem <= r_rem - 1'b1;
            if (w_last_byte) begin
              r_state  <= S_STOP;
              r_ctrl_o <= 2'b11;
            end else begin
              r_state    <= S_WR_FETCH;
              r_wr_ready <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_state    <= S_ABORT;
            r_err_code <= 2'b10;
            r_ctrl_o   <= 2'b11;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        S_RD_TURN: begin
          r_state <= S_RD_RECV;
          r_beat  <= '0;
        end

        S_RD_RECV: begin
          r_shift <= w_shift_in;
          if (w_stop_seen) begin
            r_state    <= S_ABORT;
            r_err_code <= 2'b11;
            r_ctrl_en  <= 1'b1;
            r_ctrl_o   <= 2'b11;
          end else if (w_last_beat) begin
            r_state    <= S_RD_ACK;
            r_rd_data  <= w_shift_in;
            r_rd_valid <= 1'b1;
            r_ack_en   <= 1'b1;
            // The last byte is NACKed to tell the slave the burst is over.
            r_ack_o    <= w_last_byte;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end

        S_RD_ACK: begin
          r_ack_en <= 1'b0;
          r_rem    <= r_rem - 1'b1;
          if (w_last_byte) begin
            r_state   <= S_STOP;
            r_ctrl_en <= 1'b1;
            r_ctrl_o  <= 2'b11;
          end else begin
            r_state <= S_RD_RECV;
            r_beat  <= '0;
          end
        end

        S_STOP, S_ABORT: begin
          r_state    <= S_IDLE;
          r_ctrl_en  <= 1'b0;
          r_data_en  <= 1'b0;
          r_ack_en   <= 1'b0;
          r_wr_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= (r_state == S_STOP);
          r_err      <= (r_state == S_ABORT);
        end

        default: begin
          r_state   <= S_IDLE;
          r_ctrl_en <= 1'b0;
          r_data_en <= 1'b0;
          r_ack_en  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign io_data = r_data_en ? r_data_o : {LANE_W{1'bz}};
  assign io_ack  = r_ack_en ? r_ack_o : 1'bz;
  assign io_ctrl = r_ctrl_en ? r_ctrl_o : 2'bzz;

  assign bus.wr_ready = r_wr_ready;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.err_code = r_err_code;

endmodule

// File: tb/tb_fcp_master_burst.sv
// tb/tb_fcp_master_burst.sv - directed scoreboard bench for fcp_master_burst
module tb_fcp_master_burst;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fcp_master_burst_if #(.LEN_W(5)) bus0 ();
  fcp_master_burst_if #(.LEN_W(3)) bus1 ();

  wire [1:0] data0;
  wire       ack0;
  wire [1:0] ctrl0;
  wire [7:0] data1;
  wire       ack1;
  wire [1:0] ctrl1;

  // Slave-side bus drivers
  logic       s0_d_en, s0_a_en, s0_a, s0_c_en;
  logic [1:0] s0_d, s0_c;
  logic       s1_a_en, s1_a;

  assign data0 = s0_d_en ? s0_d : 2'bzz;
  assign ack0  = s0_a_en ? s0_a : 1'bz;
  assign ctrl0 = s0_c_en ? s0_c : 2'bzz;
  assign ack1  = s1_a_en ? s1_a : 1'bz;

  // Every line idles high so a released bus is observable.
  pullup (ack0);
  pullup (ack1);
  for (genvar g = 0; g < 2; g++) begin : g_pu0
    pullup (data0[g]);
    pullup (ctrl0[g]);
    pullup (ctrl1[g]);
  end
  for (genvar g = 0; g < 8; g++) begin : g_pu1
    pullup (data1[g]);
  end

  fcp_master_burst #(.LANE_W(2), .MAX_LEN(16), .ACK_TIMEOUT(15)) u0 (
    .i_clk(clk), .i_rst(rst), .bus(bus0.master),
    .io_data(data0), .io_ack(ack0), .io_ctrl(ctrl0)
  );

  fcp_master_burst #(.LANE_W(8), .MAX_LEN(4), .ACK_TIMEOUT(15)) u1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1.master),
    .io_data(data1), .io_ack(ack1), .io_ctrl(ctrl1)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cnt_done0 = 0, cnt_err0 = 0, cnt_rdv0 = 0;
  int cnt_done1 = 0, cnt_err1 = 0;

  logic [7:0] exp_rd[$];
  logic       exp_ack[$];
  logic [7:0] exp_beat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse counters and read scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus0.done) cnt_done0 <= cnt_done0 + 1;
    if (bus0.err)  cnt_err0  <= cnt_err0 + 1;
    if (bus1.done) cnt_done1 <= cnt_done1 + 1;
    if (bus1.err)  cnt_err1  <= cnt_err1 + 1;
    if (!rst && bus0.rd_valid) begin
      cnt_rdv0 <= cnt_rdv0 + 1;
      if (exp_rd.size() == 0) begin
        chk("rd_unexpected", 32'(bus0.rd_data), 32'h1ff);
      end else begin
        chk("rd_data", 32'(bus0.rd_data), 32'(exp_rd.pop_front()));
        chk("rd_ack", 32'(ack0), 32'(exp_ack.pop_front()));
      end
    end
  end

  // Slave drives one byte in RD_RECV, then lets the master ACK it.
  task automatic rd_byte(input logic [7:0] b, input bit last);
    for (int j = 0; j < 4; j++) begin
      s0_d_en = 1'b1;
      s0_d    = 2'((b >> (6 - 2 * j)) & 8'h03);
      tick();
    end
    s0_d_en = 1'b0;
    if (last) s0_c_en = 1'b0;
    tick();
  endtask

  task automatic start0(input logic [7:0] hdr, input logic [4:0] len);
    bus0.header_in = hdr;
    bus0.len_in    = len;
    bus0.start     = 1'b1;
    tick();
    bus0.start = 1'b0;
  endtask

  task automatic start1(input logic [7:0] hdr, input logic [2:0] len);
    bus1.header_in = hdr;
    bus1.len_in    = len;
    bus1.start     = 1'b1;
    tick();
    bus1.start = 1'b0;
  endtask

  logic [7:0] wbytes[4];
  int         d0, e0, r0, d1, e1;

  initial begin
    rst = 1'b1;
    bus0.start = 0; bus0.header_in = 0; bus0.len_in = 0; bus0.wr_data = 0; bus0.wr_valid = 0;
    bus1.start = 0; bus1.header_in = 0; bus1.len_in = 0; bus1.wr_data = 0; bus1.wr_valid = 0;
    s0_d_en = 0; s0_d = 0; s0_a_en = 0; s0_a = 1; s0_c_en = 0; s0_c = 0;
    s1_a_en = 0; s1_a = 1;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", 32'(bus0.busy), 0);
    chk("rst_done", 32'(bus0.done), 0);
    chk("rst_err", 32'(bus0.err), 0);
    chk("rst_err_code", 32'(bus0.err_code), 0);
    chk("rst_wr_ready", 32'(bus0.wr_ready), 0);
    chk("rst_rd_valid", 32'(bus0.rd_valid), 0);
    chk("rst_rd_data", 32'(bus0.rd_data), 0);
    chk("rst_data_z", 32'(data0), 32'h3);
    chk("rst_ctrl_z", 32'(ctrl0), 32'h3);
    chk("rst_ack_z", 32'(ack0), 1);
    rst = 1'b0;
    tick();

    // Write 0xA5, len 2, bytes 0x99, 0x3C, immediate ACK
    foreach (wbytes[i]) wbytes[i] = 8'h00;
    wbytes[0] = 8'hA5; wbytes[1] = 8'h99; wbytes[2] = 8'h3C;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++)
        exp_beat.push_back(8'((wbytes[i] >> (6 - 2 * j)) & 8'h03));
    s0_a_en = 1'b1; s0_a = 1'b0;
    bus0.wr_data = 8'h99; bus0.wr_valid = 1'b1;
    d0 = cnt_done0; e0 = cnt_err0;
    start0(8'hA5, 5'd2);
    for (int k = 0; k <= 18; k++) begin
      if (k < 4 || (k >= 6 && k <= 9) || (k >= 12 && k <= 15)) begin
        chk("wr_beat", 32'(data0), 32'(exp_beat.pop_front()));
        chk("wr_ctrl_own", 32'(ctrl0), 32'h1);
      end
      if (k == 6) bus0.wr_data = 8'h3C;
      if (k == 17) chk("wr_stop_ctrl", 32'(ctrl0), 32'h3);
      if (k == 17) chk("wr_busy_before_done", 32'(bus0.busy), 1);
      if (k == 17) chk("wr_done_early", 32'(bus0.done), 0);
      if (k == 18) begin
        chk("wr_done", 32'(bus0.done), 1);
        chk("wr_busy_fall", 32'(bus0.busy), 0);
        chk("wr_err", 32'(bus0.err), 0);
      end
      if (k < 18) tick();
    end
    bus0.wr_valid = 1'b0;
    s0_a_en = 1'b0;
    tick();
    chk("wr_done_once", 32'(cnt_done0 - d0), 1);
    chk("wr_no_err", 32'(cnt_err0 - e0), 0);

    // Read 0x44, len 3, slave returns 0x12, 0x34, 0x56
    exp_rd.push_back(8'h12); exp_ack.push_back(1'b0);
    exp_rd.push_back(8'h34); exp_ack.push_back(1'b0);
    exp_rd.push_back(8'h56); exp_ack.push_back(1'b1);
    d0 = cnt_done0; r0 = cnt_rdv0;
    start0(8'h44, 5'd3);
    repeat (4) tick();
    s0_a_en = 1'b1; s0_a = 1'b0;
    tick();
    s0_a_en = 1'b0;
    s0_c_en = 1'b1; s0_c = 2'b10;
    tick();
    rd_byte(8'h12, 1'b0);
    rd_byte(8'h34, 1'b0);
    rd_byte(8'h56, 1'b1);
    chk("rd_stop_ctrl", 32'(ctrl0), 32'h3);
    chk("rd_busy", 32'(bus0.busy), 1);
    tick();
    chk("rd_done", 32'(bus0.done), 1);
    chk("rd_busy_fall", 32'(bus0.busy), 0);
    tick();
    chk("rd_valid_count", 32'(cnt_rdv0 - r0), 3);
    chk("rd_done_once", 32'(cnt_done0 - d0), 1);
    chk("rd_sb_empty", 32'(exp_rd.size()), 0);

    // Header with no ACK: timeout
    e0 = cnt_err0;
    start0(8'h00, 5'd1);
    repeat (4) tick();
    repeat (15) tick();
    chk("tmo_still_waiting", 32'(ctrl0), 32'h1);
    chk("tmo_busy", 32'(bus0.busy), 1);
    tick();
    chk("tmo_no_err_yet", 32'(bus0.err), 0);
    chk("tmo_abort_busy", 32'(bus0.busy), 1);
    chk("tmo_abort_ctrl", 32'(ctrl0), 32'h3);
    tick();
    chk("tmo_err", 32'(bus0.err), 1);
    chk("tmo_err_code", 32'(bus0.err_code), 32'h1);
    chk("tmo_busy_fall", 32'(bus0.busy), 0);
    tick();
    chk("tmo_err_pulse", 32'(bus0.err), 0);
    chk("tmo_code_held", 32'(bus0.err_code), 32'h1);
    chk("tmo_err_once", 32'(cnt_err0 - e0), 1);

    // Write len 1 with wr_valid held off for 5 cycles
    s0_a_en = 1'b1; s0_a = 1'b0;
    bus0.wr_valid = 1'b0; bus0.wr_data = 8'hC3;
    start0(8'h01, 5'd1);
    chk("wait_code_cleared", 32'(bus0.err_code), 0);
    repeat (5) tick();
    for (int k = 5; k <= 10; k++) begin
      chk("wait_wr_ready", 32'(bus0.wr_ready), 1);
      if (k == 10) bus0.wr_valid = 1'b1;
      tick();
    end
    bus0.wr_valid = 1'b0;
    chk("wait_wr_ready_drop", 32'(bus0.wr_ready), 0);
    chk("wait_beat0", 32'(data0), 32'h3);
    tick();
    chk("wait_beat1", 32'(data0), 32'h0);
    repeat (4) tick();
    chk("wait_done_early", 32'(bus0.done), 0);
    tick();
    chk("wait_done", 32'(bus0.done), 1);
    s0_a_en = 1'b0;

    // LANE_W=8, MAX_LEN=4, len 7: exactly 4 bytes
    wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33; wbytes[3] = 8'h44;
    for (int i = 0; i < 4; i++) exp_beat.push_back(wbytes[i]);
    s1_a_en = 1'b1; s1_a = 1'b0;
    bus1.wr_data = wbytes[0]; bus1.wr_valid = 1'b1;
    d1 = cnt_done1;
    start1(8'h81, 3'd7);
    for (int k = 0; k <= 15; k++) begin
      if (k == 0) chk("w8_hdr", 32'(data1), 32'h81);
      if (k >= 3 && k <= 12 && (k % 3) == 0) begin
        chk("w8_byte", 32'(data1), 32'(exp_beat.pop_front()));
        if (k < 12) bus1.wr_data = wbytes[k / 3];
      end
      if (k == 14) begin
        chk("w8_stop_ctrl", 32'(ctrl1), 32'h3);
        chk("w8_no_fifth", 32'(data1), 32'hff);
      end
      if (k == 15) chk("w8_done", 32'(bus1.done), 1);
      if (k < 15) tick();
    end
    tick();
    chk("w8_done_once", 32'(cnt_done1 - d1), 1);

    // Reset in the middle of the second byte
    bus1.wr_data = wbytes[0];
    d1 = cnt_done1; e1 = cnt_err1;
    start1(8'h81, 3'd4);
    repeat (3) tick();
    bus1.wr_data = wbytes[1];
    repeat (3) tick();
    chk("rst8_byte1", 32'(data1), 32'h22);
    chk("rst8_busy_pre", 32'(bus1.busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst8_data_z", 32'(data1), 32'hff);
    chk("rst8_ctrl_z", 32'(ctrl1), 32'h3);
    chk("rst8_busy", 32'(bus1.busy), 0);
    bus1.wr_valid = 1'b0;
    repeat (4) tick();
    chk("rst8_no_done", 32'(cnt_done1 - d1), 0);
    chk("rst8_no_err", 32'(cnt_err1 - e1), 0);
    s1_a_en = 1'b0;

    // Read where slave signals stop during the second byte
    exp_rd.push_back(8'h12); exp_ack.push_back(1'b0);
    e0 = cnt_err0; r0 = cnt_rdv0;
    start0(8'h44, 5'd3);
    repeat (4) tick();
    s0_a_en = 1'b1; s0_a = 1'b0;
    tick();
    s0_a_en = 1'b0;
    s0_c_en = 1'b1; s0_c = 2'b10;
    tick();
    rd_byte(8'h12, 1'b0);
    s0_d_en = 1'b1; s0_d = 2'b00;
    tick();
    s0_d = 2'b11; s0_c = 2'b11;
    tick();
    s0_d_en = 1'b0; s0_c_en = 1'b0;
    chk("stop_abort_busy", 32'(bus0.busy), 1);
    tick();
    chk("stop_err", 32'(bus0.err), 1);
    chk("stop_err_code", 32'(bus0.err_code), 32'h3);
    chk("stop_busy_fall", 32'(bus0.busy), 0);
    tick();
    chk("stop_rd_valid_count", 32'(cnt_rdv0 - r0), 1);
    chk("stop_err_once", 32'(cnt_err0 - e0), 1);
    chk("stop_sb_empty", 32'(exp_rd.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
